// File: rtl/keyreg_pkg.sv
// Shared constants for the keypad entry buffer: FSM encodings and BCD/time-of-day limits.
package keyreg_pkg;

    localparam int unsigned BCD_W           = 4;
    localparam int unsigned KEY_MAX_DEC     = 9;
    localparam int unsigned HR_MS_MAX       = 2;
    localparam int unsigned HR_LS_MAX_AT_20 = 3;
    localparam int unsigned MIN_MS_MAX      = 5;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ENTRY = 2'd1;
    localparam logic [1:0] ST_HOLD  = 2'd2;

endpackage

// File: rtl/time_digit_check.sv
// Combinational HH:MM range check on four BCD digits (digit 3 = MS hour, digit 0 = LS minute).
module time_digit_check
    import keyreg_pkg::*;
#(
    parameter int unsigned DIGIT_W = BCD_W
) (
    input  logic [4*DIGIT_W-1:0] i_digits,
    output logic                 o_ok_c
);

    logic [DIGIT_W-1:0] w_ms_hr;
    logic [DIGIT_W-1:0] w_ls_hr;
    logic [DIGIT_W-1:0] w_ms_min;
    logic [DIGIT_W-1:0] w_ls_min;
    logic               w_hr_ok;

    assign w_ms_hr  = i_digits[3*DIGIT_W +: DIGIT_W];
    assign w_ls_hr  = i_digits[2*DIGIT_W +: DIGIT_W];
    assign w_ms_min = i_digits[1*DIGIT_W +: DIGIT_W];
    assign w_ls_min = i_digits[0*DIGIT_W +: DIGIT_W];

    // Hours 20..23 limit the LS hour digit to 3; 00..19 allow any decimal digit.
    assign w_hr_ok = (32'(w_ms_hr) < HR_MS_MAX)  ? (32'(w_ls_hr) <= KEY_MAX_DEC) :
                     (32'(w_ms_hr) == HR_MS_MAX) ? (32'(w_ls_hr) <= HR_LS_MAX_AT_20) : 1'b0;

    assign o_ok_c = w_hr_ok
                  && (32'(w_ms_min) <= MIN_MS_MAX)
                  && (32'(w_ls_min) <= KEY_MAX_DEC);

endmodule

// File: rtl/key_entry_buffer.sv
// Keypad digit entry buffer with backspace, clear, inactivity timeout and a validated commit
// that hands the value to the consumer over a valid/ready handshake.
module key_entry_buffer
    import keyreg_pkg::*;
#(
    parameter int unsigned DIGITS        = 4,
    parameter int unsigned DIGIT_W       = BCD_W,
    parameter int unsigned TIMEOUT_TICKS = 10,
    parameter int unsigned VALIDATE_TIME = 1
) (
    input  logic                         i_clk,
    input  logic                         i_rst_n,
    input  logic                         i_tick,
    input  logic                         i_shift,
    input  logic [DIGIT_W-1:0]           i_key,
    input  logic                         i_backspace,
    input  logic                         i_clear,
    input  logic                         i_commit,
    output logic [DIGITS*DIGIT_W-1:0]    o_buf_data,
    output logic [$clog2(DIGITS+1)-1:0]  o_count,
    output logic                         o_entry_active,
    output logic [DIGITS*DIGIT_W-1:0]    o_out_data,
    output logic                         o_out_valid,
    input  logic                         i_out_ready,
    output logic                         o_err,
    output logic                         o_timed_out
);

    localparam int unsigned BUF_W = DIGITS * DIGIT_W;
    localparam int unsigned CNT_W = $clog2(DIGITS + 1);
    localparam int unsigned TO_W  = (TIMEOUT_TICKS > 0) ? $clog2(TIMEOUT_TICKS + 1) : 1;

    logic [1:0]       r_state,        w_nxt_state;
    logic [BUF_W-1:0] r_buf,          w_nxt_buf;
    logic [CNT_W-1:0] r_count,        w_nxt_count;
    logic [BUF_W-1:0] r_out_data,     w_nxt_out_data;
    logic             r_out_valid,    w_nxt_out_valid;
    logic             r_err,          w_nxt_err;
    logic             r_timed_out,    w_nxt_timed_out;
    logic             r_entry_active;

    logic w_key_legal;
    logic w_range_ok;
    logic w_full;
    logic w_action;
    logic w_to_restart;
    logic w_to_expire;

    assign w_key_legal  = (32'(i_key) <= KEY_MAX_DEC);
    assign w_full       = (r_count == CNT_W'(DIGITS));
    assign w_action     = i_clear | i_commit | i_backspace | (i_shift & w_key_legal);
    assign w_to_restart = (r_state == ST_ENTRY) && !i_clear && !i_commit
                        && (i_backspace || (i_shift && w_key_legal));

    generate
        if (VALIDATE_TIME == 1 && DIGITS == 4) begin : g_range
            time_digit_check #(.DIGIT_W(DIGIT_W)) u_time_digit_check (
                .i_digits (r_buf),
                .o_ok_c   (w_range_ok)
            );
        end else begin : g_no_range
            assign w_range_ok = 1'b1;
        end

        // Inactivity counter: counts ticks in ENTRY, restarted by accepted digit edits.
        if (TIMEOUT_TICKS > 0) begin : g_timeout
            logic [TO_W-1:0] r_to_cnt;
            always_ff @(posedge i_clk or negedge i_rst_n) begin
                if (!i_rst_n)
                    r_to_cnt <= '0;
                else if (r_state != ST_ENTRY || w_to_restart || w_to_expire)
                    r_to_cnt <= '0;
                else if (i_tick)
                    r_to_cnt <= r_to_cnt + TO_W'(1);
            end
            assign w_to_expire = (r_state == ST_ENTRY) && i_tick && !w_action
                               && (r_to_cnt == TO_W'(TIMEOUT_TICKS - 1));
        end else begin : g_no_timeout
            assign w_to_expire = 1'b0;
        end
    endgenerate

    always_comb begin
        w_nxt_state     = r_state;
        w_nxt_buf       = r_buf;
        w_nxt_count     = r_count;
        w_nxt_out_data  = r_out_data;
        w_nxt_out_valid = r_out_valid;
        w_nxt_err       = 1'b0;
        w_nxt_timed_out = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (i_clear || (!i_commit && i_backspace)) begin
                    w_nxt_state = ST_IDLE;
                end else if (i_commit) begin
                    w_nxt_err = 1'b1;
                end else if (i_shift) begin
                    if (w_key_legal) begin
                        w_nxt_buf   = BUF_W'(i_key);
                        w_nxt_count = CNT_W'(1);
                        w_nxt_state = ST_ENTRY;
                    end else begin
                        w_nxt_err = 1'b1;
                    end
                end
            end
            ST_ENTRY: begin
                if (i_clear) begin
                    w_nxt_buf   = '0;
                    w_nxt_count = '0;
                    w_nxt_state = ST_IDLE;
                end else if (i_commit) begin
                    if (w_full && w_range_ok) begin
                        w_nxt_out_data  = r_buf;
                        w_nxt_out_valid = 1'b1;
                        w_nxt_buf       = '0;
                        w_nxt_count     = '0;
                        w_nxt_state     = ST_HOLD;
                    end else begin
                        w_nxt_err = 1'b1;
                    end
                end else if (i_backspace) begin
                    w_nxt_buf   = r_buf >> DIGIT_W;
                    w_nxt_count = r_count - CNT_W'(1);
                    if (r_count == CNT_W'(1))
                        w_nxt_state = ST_IDLE;
                end else if (i_shift && w_key_legal) begin
                    w_nxt_buf   = (r_buf << DIGIT_W) | BUF_W'(i_key);
                    w_nxt_count = w_full ? r_count : r_count + CNT_W'(1);
                end else begin
                    w_nxt_err = i_shift;
                    if (w_to_expire) begin
                        w_nxt_buf       = '0;
                        w_nxt_count     = '0;
                        w_nxt_timed_out = 1'b1;
                        w_nxt_state     = ST_IDLE;
                    end
                end
            end
            ST_HOLD: begin
                if (i_clear || i_out_ready) begin
                    w_nxt_out_valid = 1'b0;
                    w_nxt_state     = ST_IDLE;
                end
            end
            default: begin
                w_nxt_state = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state        <= ST_IDLE;
            r_buf          <= '0;
            r_count        <= '0;
            r_out_data     <= '0;
            r_out_valid    <= 1'b0;
            r_err          <= 1'b0;
            r_timed_out    <= 1'b0;
            r_entry_active <= 1'b0;
        end else begin
            r_state        <= w_nxt_state;
            r_buf          <= w_nxt_buf;
            r_count        <= w_nxt_count;
            r_out_data     <= w_nxt_out_data;
            r_out_valid    <= w_nxt_out_valid;
            r_err          <= w_nxt_err;
            r_timed_out    <= w_nxt_timed_out;
            r_entry_active <= (w_nxt_state == ST_ENTRY);
        end
    end

    assign o_buf_data     = r_buf;
    assign o_count        = r_count;
    assign o_entry_active = r_entry_active;
    assign o_out_data     = r_out_data;
    assign o_out_valid    = r_out_valid;
    assign o_err          = r_err;
    assign o_timed_out    = r_timed_out;

endmodule

// File: tb/tb_key_entry_buffer.sv
// Directed bench for key_entry_buffer: entry, commit/validation, backspace, timeout, hold, priority, reset.
module tb_key_entry_buffer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        tick = 1'b0;
    logic        shift = 1'b0;
    logic [3:0]  key = 4'd0;
    logic        backspace = 1'b0;
    logic        clear = 1'b0;
    logic        commit = 1'b0;
    logic        out_ready = 1'b0;
    logic [15:0] buf_data;
    logic [2:0]  count;
    logic        entry_active;
    logic [15:0] out_data;
    logic        out_valid;
    logic        err;
    logic        timed_out;

    int n_checks = 0;
    int n_fail   = 0;

    key_entry_buffer #(
        .DIGITS(4), .DIGIT_W(4), .TIMEOUT_TICKS(10), .VALIDATE_TIME(1)
    ) dut (
        .i_clk          (clk),
        .i_rst_n        (rst_n),
        .i_tick         (tick),
        .i_shift        (shift),
        .i_key          (key),
        .i_backspace    (backspace),
        .i_clear        (clear),
        .i_commit       (commit),
        .o_buf_data     (buf_data),
        .o_count        (count),
        .o_entry_active (entry_active),
        .o_out_data     (out_data),
        .o_out_valid    (out_valid),
        .i_out_ready    (out_ready),
        .o_err          (err),
        .o_timed_out    (timed_out)
    );

    always #5 clk = ~clk;

    // Stimulus helpers: each applies one strobe for exactly one clock, then returns #1 after the edge.
    task automatic step();
        @(posedge clk); #1;
        shift = 1'b0; backspace = 1'b0; clear = 1'b0; commit = 1'b0; tick = 1'b0; out_ready = 1'b0;
    endtask

    task automatic press(input logic [3:0] k);
        shift = 1'b1; key = k; step();
    endtask

    task automatic do_commit();
        commit = 1'b1; step();
    endtask

    task automatic do_clear();
        clear = 1'b1; step();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #12;
        n_checks++;
        if (buf_data !== 16'h0 || count !== 3'd0 || out_data !== 16'h0 || out_valid !== 1'b0
            || err !== 1'b0 || timed_out !== 1'b0 || entry_active !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_state: buf=%h cnt=%0d out=%h v=%b err=%b to=%b act=%b expected all zero",
                     buf_data, count, out_data, out_valid, err, timed_out, entry_active);
        end
        @(posedge clk); #1; rst_n = 1'b1;
        step();
    endtask

    task automatic test_commit_ok();
        press(4'd1); press(4'd2); press(4'd3); press(4'd0);
        n_checks++;
        if (buf_data !== 16'h1230 || count !== 3'd4 || entry_active !== 1'b1) begin
            n_fail++;
            $display("FAIL entry_1230: buf=%h cnt=%0d act=%b expected 1230 4 1", buf_data, count, entry_active);
        end
        do_commit();
        n_checks++;
        if (out_data !== 16'h1230 || out_valid !== 1'b1 || count !== 3'd0 || buf_data !== 16'h0 || err !== 1'b0) begin
            n_fail++;
            $display("FAIL commit_1230: out=%h v=%b cnt=%0d buf=%h err=%b expected 1230 1 0 0000 0",
                     out_data, out_valid, count, buf_data, err);
        end
        out_ready = 1'b1; step();
        n_checks++;
        if (out_valid !== 1'b0 || entry_active !== 1'b0) begin
            n_fail++;
            $display("FAIL handshake_release: v=%b act=%b expected 0 0", out_valid, entry_active);
        end
    endtask

    task automatic test_commit_range();
        press(4'd2); press(4'd4); press(4'd0); press(4'd0);
        do_commit();
        n_checks++;
        if (err !== 1'b1 || out_valid !== 1'b0 || buf_data !== 16'h2400 || entry_active !== 1'b1) begin
            n_fail++;
            $display("FAIL reject_2400: err=%b v=%b buf=%h act=%b expected 1 0 2400 1",
                     err, out_valid, buf_data, entry_active);
        end
        step();
        n_checks++;
        if (err !== 1'b0) begin
            n_fail++;
            $display("FAIL err_one_cycle: err=%b expected 0", err);
        end
        do_clear();
        press(4'd1); press(4'd2); press(4'd6); press(4'd0);
        do_commit();
        n_checks++;
        if (err !== 1'b1 || out_valid !== 1'b0 || buf_data !== 16'h1260) begin
            n_fail++;
            $display("FAIL reject_1260: err=%b v=%b buf=%h expected 1 0 1260", err, out_valid, buf_data);
        end
        do_clear();
        press(4'd1); press(4'd2);
        do_commit();
        n_checks++;
        if (err !== 1'b1 || out_valid !== 1'b0 || count !== 3'd2) begin
            n_fail++;
            $display("FAIL reject_short: err=%b v=%b cnt=%0d expected 1 0 2", err, out_valid, count);
        end
        do_clear();
        press(4'd2); press(4'd3); press(4'd5); press(4'd9);
        do_commit();
        n_checks++;
        if (err !== 1'b0 || out_valid !== 1'b1 || out_data !== 16'h2359) begin
            n_fail++;
            $display("FAIL accept_2359: err=%b v=%b out=%h expected 0 1 2359", err, out_valid, out_data);
        end
        out_ready = 1'b1; step();
    endtask

    task automatic test_backspace();
        press(4'd1); press(4'd2); press(4'd3);
        backspace = 1'b1; step();
        press(4'd5);
        n_checks++;
        if (buf_data !== 16'h0125 || count !== 3'd3) begin
            n_fail++;
            $display("FAIL backspace_0125: buf=%h cnt=%0d expected 0125 3", buf_data, count);
        end
        do_clear();
        for (int k = 1; k <= 5; k++) press(4'(k));
        n_checks++;
        if (buf_data !== 16'h2345 || count !== 3'd4) begin
            n_fail++;
            $display("FAIL overflow_2345: buf=%h cnt=%0d expected 2345 4", buf_data, count);
        end
        do_clear();
        press(4'd7);
        backspace = 1'b1; step();
        n_checks++;
        if (buf_data !== 16'h0 || count !== 3'd0 || entry_active !== 1'b0) begin
            n_fail++;
            $display("FAIL backspace_empty: buf=%h cnt=%0d act=%b expected 0000 0 0", buf_data, count, entry_active);
        end
    endtask

    task automatic test_timeout();
        press(4'd7);
        for (int t = 1; t <= 9; t++) begin
            tick = 1'b1; step();
            step();
        end
        n_checks++;
        if (timed_out !== 1'b0 || entry_active !== 1'b1 || buf_data !== 16'h0007) begin
            n_fail++;
            $display("FAIL timeout_early: to=%b act=%b buf=%h expected 0 1 0007", timed_out, entry_active, buf_data);
        end
        tick = 1'b1; step();
        n_checks++;
        if (timed_out !== 1'b1 || entry_active !== 1'b0 || buf_data !== 16'h0 || count !== 3'd0) begin
            n_fail++;
            $display("FAIL timeout_fire: to=%b act=%b buf=%h cnt=%0d expected 1 0 0000 0",
                     timed_out, entry_active, buf_data, count);
        end
        step();
        n_checks++;
        if (timed_out !== 1'b0) begin
            n_fail++;
            $display("FAIL timeout_pulse: to=%b expected 0", timed_out);
        end
    endtask

    task automatic test_hold();
        int bad = 0;
        press(4'd1); press(4'd2); press(4'd3); press(4'd0);
        do_commit();
        for (int c = 0; c < 20; c++) begin
            case (c % 4)
                0: begin shift = 1'b1; key = 4'd5; end
                1: backspace = 1'b1;
                2: commit = 1'b1;
                default: begin shift = 1'b1; key = 4'hC; end
            endcase
            step();
            n_checks++;
            if (out_data !== 16'h1230 || out_valid !== 1'b1 || err !== 1'b0 || count !== 3'd0) begin
                n_fail++;
                bad++;
                if (bad < 4)
                    $display("FAIL hold_stable[%0d]: out=%h v=%b err=%b cnt=%0d expected 1230 1 0 0",
                             c, out_data, out_valid, err, count);
            end
        end
        out_ready = 1'b1; step();
        n_checks++;
        if (out_valid !== 1'b0 || entry_active !== 1'b0) begin
            n_fail++;
            $display("FAIL hold_ready: v=%b act=%b expected 0 0", out_valid, entry_active);
        end
        press(4'd1); press(4'd2); press(4'd3); press(4'd4);
        do_commit();
        do_clear();
        n_checks++;
        if (out_valid !== 1'b0 || entry_active !== 1'b0) begin
            n_fail++;
            $display("FAIL hold_clear: v=%b act=%b expected 0 0", out_valid, entry_active);
        end
    endtask

    task automatic test_priority();
        press(4'd1); press(4'd2); press(4'd3); press(4'd0);
        clear = 1'b1; commit = 1'b1; step();
        n_checks++;
        if (out_valid !== 1'b0 || buf_data !== 16'h0 || count !== 3'd0 || err !== 1'b0 || entry_active !== 1'b0) begin
            n_fail++;
            $display("FAIL clear_over_commit: v=%b buf=%h cnt=%0d err=%b act=%b expected 0 0000 0 0 0",
                     out_valid, buf_data, count, err, entry_active);
        end
        press(4'hB);
        n_checks++;
        if (err !== 1'b1 || count !== 3'd0 || entry_active !== 1'b0) begin
            n_fail++;
            $display("FAIL illegal_idle: err=%b cnt=%0d act=%b expected 1 0 0", err, count, entry_active);
        end
        press(4'd4);
        press(4'hB);
        n_checks++;
        if (err !== 1'b1 || buf_data !== 16'h0004 || count !== 3'd1) begin
            n_fail++;
            $display("FAIL illegal_entry: err=%b buf=%h cnt=%0d expected 1 0004 1", err, buf_data, count);
        end
        commit = 1'b1; backspace = 1'b1; step();
        n_checks++;
        if (err !== 1'b1 || buf_data !== 16'h0004 || count !== 3'd1) begin
            n_fail++;
            $display("FAIL commit_over_backspace: err=%b buf=%h cnt=%0d expected 1 0004 1", err, buf_data, count);
        end
        do_clear();
    endtask

    task automatic test_reset_hold();
        press(4'd0); press(4'd9); press(4'd4); press(4'd5);
        do_commit();
        #2 rst_n = 1'b0;
        #1;
        n_checks++;
        if (out_valid !== 1'b0 || out_data !== 16'h0 || buf_data !== 16'h0 || count !== 3'd0 || entry_active !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_mid_hold: v=%b out=%h buf=%h cnt=%0d act=%b expected all zero",
                     out_valid, out_data, buf_data, count, entry_active);
        end
        @(posedge clk); #1; rst_n = 1'b1;
        step();
    endtask

    initial begin
        test_reset();
        test_commit_ok();
        test_commit_range();
        test_backspace();
        test_timeout();
        test_hold();
        test_priority();
        test_reset_hold();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
